// File: rtl/seg_scan_capture_pkg.sv
// Shared 7-segment display definitions: hex glyphs, glyph decoder, scan FSM states.
package seg_scan_capture_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned IDX_W      = 3;

    // Active-low glyphs, bit0 = a ... bit6 = g.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

    // Scan-tracking FSM states.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    // Decoded digit: ok flags a legal glyph.
    typedef struct packed {
        logic             ok;
        logic [NIB_W-1:0] value;
    } hex_dec_t;

    // Inverse of the glyph encoding; unknown patterns (including blank) give {0, 4'h0}.
    function automatic hex_dec_t seg_to_hex(input logic [SEG_W-1:0] seg);
        hex_dec_t r;
        r.ok    = 1'b1;
        r.value = 4'h0;
        case (seg)
            GLYPH_0: r.value = 4'h0;
            GLYPH_1: r.value = 4'h1;
            GLYPH_2: r.value = 4'h2;
            GLYPH_3: r.value = 4'h3;
            GLYPH_4: r.value = 4'h4;
            GLYPH_5: r.value = 4'h5;
            GLYPH_6: r.value = 4'h6;
            GLYPH_7: r.value = 4'h7;
            GLYPH_8: r.value = 4'h8;
            GLYPH_9: r.value = 4'h9;
            GLYPH_A: r.value = 4'hA;
            GLYPH_B: r.value = 4'hB;
            GLYPH_C: r.value = 4'hC;
            GLYPH_D: r.value = 4'hD;
            GLYPH_E: r.value = 4'hE;
            GLYPH_F: r.value = 4'hF;
            default: r.ok    = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with a selectable reset value.
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages to resolve metastability on asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs the eight hex digits shown on a multiplexed active-low 7-segment display.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  segments,
    input  logic [7:0]  anodes,
    output logic [31:0] digits,
    output logic [7:0]  digit_ok,
    output logic        frame_valid,
    output logic        scan_err,
    output logic        stalled
);

    localparam int unsigned SW       = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IN_W     = NUM_DIGITS + SEG_W;
    localparam bit          ONE_SHOT = (SETTLE_CYCLES <= 1);

    logic [IN_W-1:0]       w_sync;
    logic [NUM_DIGITS-1:0] w_an;
    logic [SEG_W-1:0]      w_seg;
    logic [3:0]            w_low_cnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_valid;
    logic                  w_err;
    logic                  w_an_chg;
    logic                  w_seg_chg;
    logic [SW-1:0]         w_cnt_inc;
    hex_dec_t              w_dec;

    state_t                w_state_nx;
    logic [SW-1:0]         w_cnt_nx;
    logic                  w_cap;
    logic                  w_err_pulse;
    logic                  w_timeout_hit;
    logic [NUM_DIGITS-1:0] w_seen_nx;

    state_t                r_state;
    logic [SW-1:0]         r_cnt;
    logic [NUM_DIGITS-1:0] r_prev_an;
    logic [SEG_W-1:0]      r_prev_seg;
    logic                  r_prev_err;
    logic                  r_scan_err;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] r_slot_val;
    logic [NUM_DIGITS-1:0]            r_slot_ok;
    logic [NUM_DIGITS-1:0]            r_seen;
    logic [31:0]                      r_digits;
    logic [NUM_DIGITS-1:0]            r_digit_ok;
    logic                             r_frame_valid;
    logic [TW-1:0]                    r_idle_cnt;
    logic                             r_stalled;

    // Synchronizers idle at all-ones so reset looks like a blank display, not an error.
    sync_2ff #(
        .WIDTH   (IN_W),
        .RST_VAL ({IN_W{1'b1}})
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({anodes, segments}),
        .o_q   (w_sync)
    );

    assign w_an  = w_sync[IN_W-1:SEG_W];
    assign w_seg = w_sync[SEG_W-1:0];

    // Window classification: count active anodes and locate the selected digit.
    always_comb begin
        w_low_cnt = 4'd0;
        w_idx     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!w_an[i]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_idx     = IDX_W'(i);
            end
        end
    end

    assign w_valid   = (w_low_cnt == 4'd1);
    assign w_err     = (w_low_cnt > 4'd1);
    assign w_an_chg  = (w_an != r_prev_an);
    assign w_seg_chg = (w_seg != r_prev_seg);
    assign w_cnt_inc = r_cnt + SW'(1);
    assign w_dec     = seg_to_hex(w_seg);

    // Scan FSM next state: settle on a stable window, capture once, hold until the anode moves.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_cap       = 1'b0;
        w_err_pulse = w_err && !r_prev_err;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_cnt_nx   = SW'(1);
                    w_cap      = ONE_SHOT;
                    w_state_nx = ONE_SHOT ? ST_HOLD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_an_chg || w_seg_chg) begin
                    if (w_valid) begin
                        w_cnt_nx   = SW'(1);
                        w_cap      = ONE_SHOT;
                        w_state_nx = ONE_SHOT ? ST_HOLD : ST_SETTLE;
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == SW'(SETTLE_CYCLES)) begin
                        w_cap      = 1'b1;
                        w_state_nx = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_an_chg) begin
                    if (w_valid) begin
                        w_cnt_nx   = SW'(1);
                        w_cap      = ONE_SHOT;
                        w_state_nx = ONE_SHOT ? ST_HOLD : ST_SETTLE;
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state, previous-sample history and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_prev_an  <= '1;
            r_prev_seg <= '1;
            r_prev_err <= 1'b0;
            r_scan_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_prev_an  <= w_an;
            r_prev_seg <= w_seg;
            r_prev_err <= w_err;
            r_scan_err <= w_err_pulse;
        end
    end

    assign w_timeout_hit = !w_cap && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Seen mask: cleared by a frame emit or a timeout, then the current capture is added.
    always_comb begin
        w_seen_nx = r_seen;
        if ((r_seen == '1) || w_timeout_hit) begin
            w_seen_nx = '0;
        end
        if (w_cap) begin
            w_seen_nx[w_idx] = 1'b1;
        end
    end

    // Digit slots, frame output, idle timeout and stall flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_val    <= '0;
            r_slot_ok     <= '0;
            r_seen        <= '0;
            r_digits      <= '0;
            r_digit_ok    <= '0;
            r_frame_valid <= 1'b0;
            r_idle_cnt    <= '0;
            r_stalled     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_seen        <= w_seen_nx;
            if (w_cap) begin
                r_slot_val[w_idx] <= w_dec.value;
                r_slot_ok[w_idx]  <= w_dec.ok;
            end
            if (r_seen == '1) begin
                r_digits      <= r_slot_val;
                r_digit_ok    <= r_slot_ok;
                r_frame_valid <= 1'b1;
            end
            if (w_cap) begin
                r_idle_cnt <= '0;
                r_stalled  <= 1'b0;
            end else if (r_idle_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
                if (w_timeout_hit) begin
                    r_stalled <= 1'b1;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_ok    = r_digit_ok;
    assign frame_valid = r_frame_valid;
    assign scan_err    = r_scan_err;
    assign stalled     = r_stalled;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scan table plus hand-written corner sequences.
module tb_seg_scan_capture;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 2000;
    localparam int unsigned NVEC    = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  segments;
    logic [7:0]  anodes;
    logic [31:0] digits;
    logic [7:0]  digit_ok;
    logic        frame_valid;
    logic        scan_err;
    logic        stalled;

    int tests = 0;
    int fails = 0;
    int fv_total = 0;
    int err_total = 0;

    typedef struct packed {
        logic [7:0][6:0] seg;
        logic [7:0][7:0] len;
        logic [7:0]      exp_frames;
        logic [31:0]     exp_digits;
        logic [7:0]      exp_ok;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    seg_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segments    (segments),
        .anodes      (anodes),
        .digits      (digits),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .scan_err    (scan_err),
        .stalled     (stalled)
    );

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid) fv_total++;
        if (scan_err) err_total++;
    end

    function automatic logic [6:0] glyph(input int unsigned v);
        case (v)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int unsigned idx, input logic [6:0] seg, input int unsigned n);
        logic [7:0] one_hot;
        one_hot  = 8'h01 << idx;
        anodes   = ~one_hot;
        segments = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int unsigned n);
        anodes   = 8'hFF;
        segments = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        anodes   = 8'hFF;
        segments = 7'h7F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic full_scan(input int unsigned first, input int unsigned last);
        for (int i = int'(first); i <= int'(last); i++) drive(i, glyph(i), 50);
    endtask

    initial begin
        int base_fv;
        int base_err;
        int lat;

        // Scan table.
        for (int r = 0; r < int'(NVEC); r++) begin
            for (int i = 0; i < 8; i++) begin
                vecs[r].seg[i] = glyph(i);
                vecs[r].len[i] = 8'd50;
            end
            vecs[r].exp_frames = 8'd1;
            vecs[r].exp_digits = 32'h76543210;
            vecs[r].exp_ok     = 8'hFF;
        end
        for (int i = 0; i < 8; i++) vecs[1].seg[i] = glyph(i + 8);
        vecs[1].exp_digits = 32'hFEDCBA98;
        vecs[2].seg[5]     = 7'h7E;
        vecs[2].exp_digits = 32'h76043210;
        vecs[2].exp_ok     = 8'hDF;
        for (int i = 0; i < 8; i++) vecs[3].seg[i] = glyph(7 - i);
        vecs[3].seg[3]     = 7'h7F;
        vecs[3].exp_digits = 32'h01230567;
        vecs[3].exp_ok     = 8'hF7;
        vecs[4].len[2]     = 8'd10;
        vecs[4].exp_frames = 8'd0;
        vecs[4].exp_digits = 32'h0;
        vecs[4].exp_ok     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            vecs[5].seg[i] = glyph(i + 8);
            vecs[5].len[i] = 8'(SETTLE);
            vecs[6].len[i] = 8'(SETTLE - 1);
        end
        vecs[5].exp_digits = 32'hFEDCBA98;
        vecs[6].exp_frames = 8'd0;
        vecs[6].exp_digits = 32'h0;
        vecs[6].exp_ok     = 8'h00;

        // Reset values.
        do_reset();
        check("reset digits", digits, 32'h0);
        check("reset digit_ok", {24'h0, digit_ok}, 32'h0);
        check("reset frame_valid", {31'h0, frame_valid}, 32'h0);
        check("reset scan_err", {31'h0, scan_err}, 32'h0);
        check("reset stalled", {31'h0, stalled}, 32'h0);

        for (int r = 0; r < int'(NVEC); r++) begin
            do_reset();
            base_fv  = fv_total;
            base_err = err_total;
            blank(4);
            for (int i = 0; i < 8; i++) drive(i, vecs[r].seg[i], vecs[r].len[i]);
            blank(6);
            check($sformatf("vec%0d frames", r), fv_total - base_fv, {24'h0, vecs[r].exp_frames});
            check($sformatf("vec%0d digits", r), digits, vecs[r].exp_digits);
            check($sformatf("vec%0d digit_ok", r), {24'h0, digit_ok}, {24'h0, vecs[r].exp_ok});
            check($sformatf("vec%0d scan_err", r), err_total - base_err, 32'd0);
        end

        // Short window in one scan, then a full scan completes the frame.
        do_reset();
        base_fv = fv_total;
        blank(4);
        for (int i = 0; i < 8; i++) drive(i, glyph(i), (i == 2) ? 10 : 50);
        blank(6);
        check("short scan frames", fv_total - base_fv, 32'd0);
        full_scan(0, 7);
        blank(6);
        check("rescan frames", fv_total - base_fv, 32'd1);
        check("rescan digits", digits, 32'h76543210);

        // Multi-anode window mid-scan.
        do_reset();
        base_fv  = fv_total;
        base_err = err_total;
        blank(4);
        full_scan(0, 3);
        anodes   = 8'hFC;
        segments = glyph(8);
        lat      = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (scan_err && lat == 0) lat = k;
        end
        full_scan(4, 7);
        blank(6);
        check("scan_err latency", lat, 32'd3);
        check("scan_err count", err_total - base_err, 32'd1);
        check("err scan frames", fv_total - base_fv, 32'd1);
        check("err scan digits", digits, 32'h76543210);

        // Timeout discards the partial frame; a capture clears stalled.
        do_reset();
        blank(4);
        full_scan(0, 2);
        blank(TIMEOUT - 200);
        check("stalled before timeout", {31'h0, stalled}, 32'h0);
        blank(300);
        check("stalled after timeout", {31'h0, stalled}, 32'h1);
        base_fv = fv_total;
        drive(3, glyph(3), 50);
        check("stalled cleared", {31'h0, stalled}, 32'h0);
        full_scan(4, 7);
        blank(6);
        check("timeout discard frames", fv_total - base_fv, 32'd0);
        full_scan(0, 2);
        blank(6);
        check("post-timeout frames", fv_total - base_fv, 32'd1);
        check("post-timeout digits", digits, 32'h76543210);

        // Reset after seven captures.
        do_reset();
        blank(4);
        full_scan(0, 6);
        #2 rst_n = 1'b0;
        anodes   = 8'hFF;
        segments = 7'h7F;
        @(negedge clk);
        check("midreset frame_valid", {31'h0, frame_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        blank(4);
        base_fv = fv_total;
        full_scan(0, 6);
        check("midreset no early frame", fv_total - base_fv, 32'd0);
        full_scan(7, 7);
        blank(6);
        check("midreset frames", fv_total - base_fv, 32'd1);
        check("midreset digits", digits, 32'h76543210);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
